// File: rtl/serial_parity_pkg.sv
// ============================================================================
// Module      : serial_parity_pkg
// Description : Shared types and constants for the serial parity engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_parity_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DATA  = 2'b01,
        CHECK = 2'b10
    } sp_state_e;

    // Operating mode latched at frame start
    localparam logic MODE_GEN = 1'b0;
    localparam logic MODE_CHK = 1'b1;

    // Parity sense latched at frame start
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit that makes the frame even (or odd) given the XOR of its data
    function automatic logic frame_parity(input logic acc, input logic odd);
        return acc ^ odd;
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_parity_bitcnt.sv
// ============================================================================
// Module      : serial_parity_bitcnt
// Description : Up-counter of accepted data bits with enable, synchronous
//               clear and a terminal flag on the increment reaching FRAME_LEN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_bitcnt #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment so a frame end can reset the count even when
    // the final bit is being accepted in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High when this cycle's increment brings the count to FRAME_LEN
    assign term = en && (cnt_q == CNT_W'(FRAME_LEN - 1));
    assign cnt  = cnt_q;

endmodule

`default_nettype wire

// File: rtl/serial_parity_engine.sv
// ============================================================================
// Module      : serial_parity_engine
// Description : Serial parity generator / checker for FRAME_LEN-bit frames,
//               one bit per accepted (in_valid) cycle, registered results.
//               Optional saturating error counter enabled by the macro
//               SERIAL_PARITY_ERR_CNT_EN (adds ERR_CNT_W and port err_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_engine
    import serial_parity_pkg::*;
#(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = $clog2(FRAME_LEN + 1)
`ifdef SERIAL_PARITY_ERR_CNT_EN
   ,parameter int ERR_CNT_W = 8
`endif
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             chk_mode,
    input  logic             odd_sel,
    output logic             busy,
    output logic [CNT_W-1:0] bit_idx,
    output logic             par_valid,
    output logic             par_bit,
    output logic             par_err
`ifdef SERIAL_PARITY_ERR_CNT_EN
   ,output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    sp_state_e state_q, state_d;
    logic      acc_q, acc_d;
    logic      mode_q, mode_d;
    logic      odd_q, odd_d;
    logic      par_valid_q, par_valid_d;
    logic      par_bit_q, par_bit_d;
    logic      par_err_q, par_err_d;

    logic      cnt_en;
    logic      cnt_clr;
    logic      cnt_term;

    // Data bits are counted in IDLE (first bit) and DATA; the parity bit in
    // CHECK is not a data bit. Kept outside the FSM block so the terminal
    // flag it feeds back does not form a block-level loop.
    assign cnt_en = in_valid && !clr && (state_q != CHECK);

    serial_parity_bitcnt #(
        .FRAME_LEN (FRAME_LEN),
        .CNT_W     (CNT_W)
    ) u_bitcnt (
        .clk   (clk),
        .arstn (arstn),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (bit_idx),
        .term  (cnt_term)
    );

    // Next-state, accumulator and result computation
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        mode_d      = mode_q;
        odd_d       = odd_q;
        par_valid_d = 1'b0;
        par_err_d   = 1'b0;
        par_bit_d   = par_bit_q;
        cnt_clr     = 1'b0;

        if (clr) begin
            state_d = IDLE;
            acc_d   = 1'b0;
            cnt_clr = 1'b1;
        end else if (in_valid) begin
            case (state_q)
                IDLE: begin
                    mode_d  = chk_mode ? MODE_CHK : MODE_GEN;
                    odd_d   = odd_sel ? PAR_ODD : PAR_EVEN;
                    acc_d   = in_bit;
                    state_d = DATA;
                end
                DATA: begin
                    acc_d = acc_q ^ in_bit;
                    if (cnt_term) begin
                        if (mode_q == MODE_CHK) begin
                            state_d = CHECK;
                        end else begin
                            par_valid_d = 1'b1;
                            par_bit_d   = frame_parity(acc_q ^ in_bit, odd_q);
                            acc_d       = 1'b0;
                            cnt_clr     = 1'b1;
                            state_d     = IDLE;
                        end
                    end
                end
                CHECK: begin
                    par_valid_d = 1'b1;
                    par_bit_d   = in_bit;
                    par_err_d   = (frame_parity(acc_q, odd_q) != in_bit);
                    acc_d       = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = IDLE;
                end
                default: begin
                    acc_d   = 1'b0;
                    cnt_clr = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, accumulator, latched mode and registered result outputs
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q     <= IDLE;
            acc_q       <= 1'b0;
            mode_q      <= MODE_GEN;
            odd_q       <= PAR_EVEN;
            par_valid_q <= 1'b0;
            par_bit_q   <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            mode_q      <= mode_d;
            odd_q       <= odd_d;
            par_valid_q <= par_valid_d;
            par_bit_q   <= par_bit_d;
            par_err_q   <= par_err_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign par_valid = par_valid_q;
    assign par_bit   = par_bit_q;
    assign par_err   = par_err_q;

`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Saturating count of parity errors; advances together with par_err
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (par_err_d && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end
    end

    // Error counter register, cleared only by the asynchronous reset
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_engine.sv
// ============================================================================
// Module      : tb_serial_parity_engine
// Description : Self-checking bench for serial_parity_engine: directed frames
//               plus randomized traffic against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_engine;

    localparam int FRAME_LEN = 8;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    logic             clk;
    logic             arstn;
    logic             clr;
    logic             in_valid;
    logic             in_bit;
    logic             chk_mode;
    logic             odd_sel;
    logic             busy;
    logic [CNT_W-1:0] bit_idx;
    logic             par_valid;
    logic             par_bit;
    logic             par_err;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [7:0]       err_cnt;
`endif

    serial_parity_engine #(
        .FRAME_LEN (FRAME_LEN)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .chk_mode  (chk_mode),
        .odd_sel   (odd_sel),
        .busy      (busy),
        .bit_idx   (bit_idx),
        .par_valid (par_valid),
        .par_bit   (par_bit),
        .par_err   (par_err)
`ifdef SERIAL_PARITY_ERR_CNT_EN
       ,.err_cnt   (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Frame-level reference model
    bit q_bits[$];
    bit m_in_frame;
    bit m_await_par;
    bit m_mode;
    bit m_odd;
    bit exp_pv;
    bit exp_pb;
    bit exp_pe;
    int exp_err;

    int cyc        = 0;
    int pulses     = 0;
    int last_pulse = -1;
    int prev_pulse = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit ones_parity();
        int n = 0;
        foreach (q_bits[i]) n += q_bits[i];
        return bit'(n % 2);
    endfunction

    task automatic model_reset();
        q_bits.delete();
        m_in_frame  = 0;
        m_await_par = 0;
        m_mode      = 0;
        m_odd       = 0;
        exp_pv      = 0;
        exp_pb      = 0;
        exp_pe      = 0;
        exp_err     = 0;
    endtask

    task automatic model_update(input bit v, input bit b, input bit cm, input bit os, input bit c);
        exp_pv = 0;
        exp_pe = 0;
        if (c) begin
            q_bits.delete();
            m_in_frame  = 0;
            m_await_par = 0;
        end else if (v) begin
            if (!m_in_frame) begin
                m_in_frame = 1;
                m_mode     = cm;
                m_odd      = os;
                q_bits.delete();
                q_bits.push_back(b);
            end else if (m_await_par) begin
                exp_pv = 1;
                exp_pb = b;
                exp_pe = ((ones_parity() ^ m_odd) != b);
                if (exp_pe && exp_err < 255) exp_err++;
                m_in_frame  = 0;
                m_await_par = 0;
                q_bits.delete();
            end else begin
                q_bits.push_back(b);
                if (q_bits.size() == FRAME_LEN) begin
                    if (m_mode) begin
                        m_await_par = 1;
                    end else begin
                        exp_pv = 1;
                        exp_pb = ones_parity() ^ m_odd;
                        m_in_frame = 0;
                        q_bits.delete();
                    end
                end
            end
        end
    endtask

    // One clock: drive inputs, let the DUT sample them, compare at negedge
    task automatic step(input bit v, input bit b, input bit cm, input bit os, input bit c);
        in_valid = v;
        in_bit   = b;
        chk_mode = cm;
        odd_sel  = os;
        clr      = c;
        @(posedge clk);
        model_update(v, b, cm, os, c);
        cyc++;
        @(negedge clk);
        check_eq("par_valid", par_valid, exp_pv);
        check_eq("par_err", par_err, exp_pe);
        check_eq("busy", busy, m_in_frame);
        check_eq("bit_idx", bit_idx, m_in_frame ? q_bits.size() : 0);
        if (exp_pv) check_eq("par_bit", par_bit, exp_pb);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        check_eq("err_cnt", err_cnt, exp_err);
`endif
        if (par_valid) begin
            pulses++;
            prev_pulse = last_pulse;
            last_pulse = cyc;
        end
    endtask

    task automatic do_reset();
        arstn = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        logic [7:0] pat_a;
        logic [7:0] pat_b;
        int         p0;

        arstn = 1'b0; clr = 0; in_valid = 0; in_bit = 0; chk_mode = 0; odd_sel = 0;
        model_reset();
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_idx", bit_idx, 0);
        check_eq("rst_pv", par_valid, 0);
        check_eq("rst_pb", par_bit, 0);
        check_eq("rst_pe", par_err, 0);
        @(negedge clk);
        arstn = 1'b1;

        // Generate, even, bits 1,0,1,1,0,0,0,0
        pat_a = 8'b0000_1101;
        for (int i = 0; i < 8; i++) step(1, pat_a[i], 0, 0, 0);
        check_eq("gen_even_pv", par_valid, 1);
        check_eq("gen_even_pb", par_bit, 1);
        check_eq("gen_even_pe", par_err, 0);
        step(0, 0, 0, 0, 0);

        // Generate, odd, stall 3 cycles after bit 4
        for (int i = 0; i < 4; i++) step(1, pat_a[i], 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 1, 0, 0);
            check_eq("stall_idx", bit_idx, 4);
        end
        for (int i = 4; i < 8; i++) step(1, pat_a[i], 1, 0, 0);
        check_eq("gen_odd_pb", par_bit, 0);
        step(0, 0, 0, 0, 0);

        // Check, even, 0xFF with bad then good parity
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
        step(1, 1, 0, 1, 0);
        check_eq("chk_bad_pe", par_err, 1);
        check_eq("chk_bad_pb", par_bit, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        check_eq("chk_good_pv", par_valid, 1);
        check_eq("chk_good_pe", par_err, 0);
`ifdef SERIAL_PARITY_ERR_CNT_EN
        check_eq("err_cnt_one", err_cnt, 1);
`endif

        // Back-to-back generate frames, 16 consecutive bits
        pat_b = 8'b1110_0101;
        for (int i = 0; i < 8; i++) step(1, pat_a[i], 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, pat_b[i], 0, 0, 0);
        check_eq("b2b_gap", last_pulse - prev_pulse, 8);
        check_eq("b2b_pb", par_bit, 1);
        step(0, 0, 0, 0, 0);

        // clr after bit 5 abandons the frame
        p0 = pulses;
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        check_eq("clr_idx", bit_idx, 0);
        check_eq("clr_busy", busy, 0);
        pat_b = 8'b0000_0111;
        for (int i = 0; i < 8; i++) step(1, pat_b[i], 0, 0, 0);
        check_eq("clr_pulses", pulses - p0, 1);
        check_eq("clr_new_pb", par_bit, 1);
        step(0, 0, 0, 0, 0);

        // Asynchronous reset while waiting for the parity bit
        for (int i = 0; i < 8; i++) step(1, i[0], 1, 0, 0);
        check_eq("pre_rst_idx", bit_idx, 8);
        check_eq("pre_rst_busy", busy, 1);
        arstn = 1'b0;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_idx", bit_idx, 0);
        check_eq("arst_pv", par_valid, 0);
        check_eq("arst_pe", par_err, 0);
        model_reset();
        @(negedge clk);
        arstn = 1'b1;

        // 300 parity errors
        for (int f = 0; f < 300; f++) begin
            for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0);
            step(1, 1, 0, 0, 0);
        end
`ifdef SERIAL_PARITY_ERR_CNT_EN
        check_eq("err_cnt_sat", err_cnt, 255);
`endif
        check_eq("sat_last_pe", par_err, 1);

        // Randomized traffic with stalls, mode changes and occasional clr
        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), ($urandom_range(0, 63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
